// File: rtl/oldland_bus_defs.sv
// Shared encodings for the oldland memory arbiter.
// Grant state values double as the owner code driven on the owner port.
package oldland_bus_defs;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GNT_I = 2'b01,
      ST_GNT_D = 2'b10
   } arb_state_t;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_I    = 2'b01;
   localparam logic [1:0] OWNER_D    = 2'b10;

   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/oldland_rr_pick2.sv
// Two-way round-robin chooser between the I$ and D$ requesters.
// On a tie the side that was not served last wins.
module oldland_rr_pick2
   import oldland_bus_defs::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last,
   output logic pick_i,
   output logic pick_d
);

   assign pick_d = req_d && (!req_i || last == LAST_I);
   assign pick_i = req_i && !pick_d;

endmodule

// File: rtl/oldland_mem_arbiter.sv
// Round-robin burst-hold arbiter sharing one bus between I$ and D$.
// Define OLDLAND_ARB_TIMEOUT_EN to force an error on a stalled grant.
module oldland_mem_arbiter
   import oldland_bus_defs::*;
#(
   parameter int max_burst      = 8,
   parameter int timeout_cycles = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_access,
   input  logic [29:0] i_addr,
   output logic [31:0] i_data,
   output logic        i_ack,
   output logic        i_error,
   input  logic        d_access,
   input  logic [29:0] d_addr,
   input  logic [3:0]  d_bytesel,
   input  logic        d_wr_en,
   input  logic [31:0] d_wr_val,
   output logic [31:0] d_data,
   output logic        d_ack,
   output logic        d_error,
   output logic        m_access,
   output logic [29:0] m_addr,
   output logic [3:0]  m_bytesel,
   output logic        m_wr_en,
   output logic [31:0] m_wr_val,
   input  logic [31:0] m_data,
   input  logic        m_ack,
   input  logic        m_error,
   output logic [1:0]  owner
);

   localparam int BW = (max_burst > 1) ? $clog2(max_burst) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(max_burst - 1);

   arb_state_t    state;
   logic [BW-1:0] burst_cnt;
   logic          rr_last;
   logic          pick_i;
   logic          pick_d;
   logic          gnt_i;
   logic          gnt_d;
   logic          own_access;
   logic          timeout;
   logic          release_bus;

   oldland_rr_pick2 u_pick (
      .req_i  (i_access),
      .req_d  (d_access),
      .last   (rr_last),
      .pick_i (pick_i),
      .pick_d (pick_d)
   );

   assign gnt_i      = (state == ST_GNT_I);
   assign gnt_d      = (state == ST_GNT_D);
   assign own_access = (gnt_i && i_access) || (gnt_d && d_access);

`ifdef OLDLAND_ARB_TIMEOUT_EN
   localparam int TW = $clog2(timeout_cycles + 1);
   logic [TW-1:0] tmo_cnt;

   assign timeout = own_access && !m_ack && !m_error
                    && (tmo_cnt == TW'(timeout_cycles - 1));

   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE || m_ack)
         tmo_cnt <= '0;
      else if (own_access)
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif

   assign release_bus = (gnt_i || gnt_d)
                        && (!own_access || m_error || timeout
                            || (m_ack && burst_cnt == LAST_BEAT));

   // Bus fields pass straight through from the owner; nothing is registered.
   assign m_access  = own_access && !timeout;
   assign m_addr    = gnt_i ? i_addr : (gnt_d ? d_addr : '0);
   assign m_bytesel = gnt_i ? 4'b1111 : (gnt_d ? d_bytesel : 4'b0000);
   assign m_wr_en   = gnt_d && d_wr_en;
   assign m_wr_val  = gnt_d ? d_wr_val : '0;

   assign i_data  = m_data;
   assign d_data  = m_data;
   assign i_ack   = gnt_i && m_ack && !m_error;
   assign d_ack   = gnt_d && m_ack && !m_error;
   assign i_error = gnt_i && (m_error || timeout);
   assign d_error = gnt_d && (m_error || timeout);
   assign owner   = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         burst_cnt <= '0;
         rr_last   <= LAST_I;
      end else begin
         unique case (state)
            ST_IDLE: begin
               burst_cnt <= '0;
               if (pick_d)
                  state <= ST_GNT_D;
               else if (pick_i)
                  state <= ST_GNT_I;
            end
            ST_GNT_I, ST_GNT_D: begin
               if (release_bus) begin
                  state     <= ST_IDLE;
                  rr_last   <= gnt_d ? LAST_D : LAST_I;
                  burst_cnt <= '0;
               end else if (m_ack) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

endmodule
